// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM plus MMIO cycle counter, tohost and scratch for the core dmem port
//   clk, rst_n           clock, asynchronous active-low reset
//   dmem_addr/wdata      byte address and right-justified store data
//   mask, dmem_wen       store size (byte/half/word/none) and store strobe
//   dmem_rdata           combinational load data, word >> 8*offset
//   sim_done/sim_code    sticky first tohost write and its value
//   misalign_err/pulse   sticky and one-cycle misaligned-store indicators
module dmem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [1:0]  mask,
  input  logic        dmem_wen,
  output logic [31:0] dmem_rdata,
  output logic        sim_done,
  output logic [31:0] sim_code,
  output logic        misalign_err,
  output logic        misalign_pulse
);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [63:0] cyc;
  logic [31:0] scratch;
  logic [1:0]  off;
  logic [ADDR_WIDTH-1:0] widx;
  logic        is_mmio, is_ram, misal, do_st;
  logic [3:0]  be;
  logic [31:0] wd, mmio_word, rword;

  assign off     = dmem_addr[1:0];
  assign widx    = dmem_addr[ADDR_WIDTH+1:2];
  assign is_mmio = dmem_addr[31:4] == MMIO_BASE[31:4];
  assign is_ram  = dmem_addr[31:ADDR_WIDTH+2] == '0;
  assign misal   = dmem_wen && ((mask == 2'b01 && off[0]) || (mask == 2'b10 && off != 2'b00));
  assign do_st   = dmem_wen && mask != 2'b11 && !misal;
  // Lane enables shifted to the offset; data replicated so every lane sees its byte.
  assign be = mask == 2'b00 ? 4'b0001 << off : mask == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign wd = mask == 2'b00 ? {4{dmem_wdata[7:0]}} : mask == 2'b01 ? {2{dmem_wdata[15:0]}} : dmem_wdata;

  always_comb begin
    mmio_word  = dmem_addr[3:2] == 2'd0 ? cyc[31:0] :
                 dmem_addr[3:2] == 2'd1 ? cyc[63:32] :
                 dmem_addr[3:2] == 2'd2 ? sim_code : scratch;
    rword      = is_mmio ? mmio_word : is_ram ? mem[widx] : 32'd0;
    dmem_rdata = rword >> {off, 3'b000};
  end

  // RAM is never reset; a store is dropped while rst_n is held low.
  always_ff @(posedge clk) begin
    if (rst_n && do_st && is_ram)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i+:8] <= wd[8*i+:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc            <= '0;
      scratch        <= '0;
      sim_done       <= 1'b0;
      sim_code       <= '0;
      misalign_err   <= 1'b0;
      misalign_pulse <= 1'b0;
    end else begin
      cyc            <= cyc + 64'd1;
      misalign_pulse <= misal;
      misalign_err   <= misalign_err | misal;
      if (do_st && is_mmio && dmem_addr[3:2] == 2'd3)
        for (int i = 0; i < 4; i++)
          if (be[i]) scratch[8*i+:8] <= wd[8*i+:8];
      if (do_st && is_mmio && dmem_addr[3:2] == 2'd2 && mask == 2'b10 && !sim_done) begin
        sim_done <= 1'b1;
        sim_code <= dmem_wdata;
      end
    end
  end
endmodule
